// File: rtl/mul_div_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_sequencer_if
// Brief    : Request/result and external-ALU signal bundle for the
//            shift-add multiply / restoring divide sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface mul_div_sequencer_if;
    // request side
    logic        start;
    logic        op_div;
    logic [15:0] a_in;
    logic [15:0] b_in;
    // result side
    logic        busy;
    logic        done;
    logic [15:0] res_lo;
    logic [15:0] res_hi;
    logic        div_zero;
    // external ALU
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [4:0]  alu_op;
    logic [15:0] alu_q;
    logic        alu_ovf;

    // requester that also hosts the ALU
    modport master (
        output start, op_div, a_in, b_in,
        input  busy, done, res_lo, res_hi, div_zero,
        input  alu_a, alu_b, alu_op,
        output alu_q, alu_ovf
    );

    // the sequencer itself
    modport slave (
        input  start, op_div, a_in, b_in,
        output busy, done, res_lo, res_hi, div_zero,
        output alu_a, alu_b, alu_op,
        input  alu_q, alu_ovf
    );
endinterface
`default_nettype wire

// File: rtl/mul_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_sequencer
// Brief    : 16x16 unsigned multiply (shift-add) and 16/16 unsigned divide
//            (restoring) sequenced over 16 cycles through an external ALU.
// Revision : 1.0  initial release
// ============================================================================
module mul_div_sequencer (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mul_div_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] C_OP_NOP = 5'b00000;
    localparam logic [4:0] C_OP_ADD = 5'b00001;
    localparam logic [4:0] C_OP_SUB = 5'b00011;

    state_t      r_state;
    logic [3:0]  r_count;
    logic        r_opDiv;
    // r_hi holds P (multiply) or R (divide); r_lo holds M or D.
    // r_opnd holds the multiplicand or the divisor.
    logic [15:0] r_hi;
    logic [15:0] r_lo;
    logic [15:0] r_opnd;
    logic        r_busy;
    logic        r_done;
    logic        r_divZero;

    logic [15:0] w_shift;
    logic        w_qBit;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign w_shift = {r_hi[14:0], r_lo[15]};
    // The subtract succeeds if the 17-bit shifted remainder is >= divisor:
    // either the bit shifted out of R was set, or the ALU produced no borrow.
    assign w_qBit  = r_hi[15] | bus.alu_ovf;

    // ALU operand/opcode drive; idle opcode outside ITER.
    always_comb begin
        bus.alu_op = C_OP_NOP;
        bus.alu_a  = 16'h0000;
        bus.alu_b  = 16'h0000;
        if (r_state == ITER) begin
            if (r_opDiv) begin
                bus.alu_op = C_OP_SUB;
                bus.alu_a  = w_shift;
                bus.alu_b  = r_opnd;
            end else begin
                bus.alu_op = C_OP_ADD;
                bus.alu_a  = r_lo[0] ? r_opnd : 16'h0000;
                bus.alu_b  = r_hi;
            end
        end
    end

    // Sequencer FSM with its datapath registers and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_count   <= 4'd0;
            r_opDiv   <= 1'b0;
            r_hi      <= 16'h0000;
            r_lo      <= 16'h0000;
            r_opnd    <= 16'h0000;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divZero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_count   <= 4'd0;
                        r_opDiv   <= bus.op_div;
                        r_divZero <= 1'b0;
                        if (bus.op_div && (bus.b_in == 16'h0000)) begin
                            // Divide by zero short-circuits straight to DONE.
                            r_hi      <= bus.a_in;
                            r_lo      <= 16'hFFFF;
                            r_opnd    <= 16'h0000;
                            r_divZero <= 1'b1;
                            r_done    <= 1'b1;
                            r_state   <= DONE;
                        end else begin
                            r_hi    <= 16'h0000;
                            r_lo    <= bus.op_div ? bus.a_in : bus.b_in;
                            r_opnd  <= bus.op_div ? bus.b_in : bus.a_in;
                            r_busy  <= 1'b1;
                            r_state <= ITER;
                        end
                    end
                end
                ITER: begin
                    if (r_opDiv) begin
                        r_hi <= w_qBit ? bus.alu_q : w_shift;
                        r_lo <= {r_lo[14:0], w_qBit};
                    end else begin
                        r_hi <= {bus.alu_ovf, bus.alu_q[15:1]};
                        r_lo <= {bus.alu_q[0], r_lo[15:1]};
                    end
                    r_count <= r_count + 4'd1;
                    if (r_count == 4'd15) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.res_hi   = r_hi;
    assign bus.res_lo   = r_lo;
    assign bus.div_zero = r_divZero;

endmodule
`default_nettype wire

// File: doc/mul_div_sequencer.md
MUL_DIV_SEQUENCER -- requirements
Module: mul_div_sequencer

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op_div  input  1  0 = unsigned multiply, 1 = unsigned divide; sampled with start.
REQ-006 a_in  input  16  multiplicand or dividend; sampled with start.
REQ-007 b_in  input  16  multiplier or divisor; sampled with start.
REQ-008 busy  output  1  high while iterating.
REQ-009 done  output  1  one-cycle pulse; results valid.
REQ-010 res_lo  output  16  product[15:0] or quotient.
REQ-011 res_hi  output  16  product[31:16] or remainder.
REQ-012 div_zero  output  1  last divide had divisor 0; held with results.
REQ-013 alu_a, alu_b  output  16 each  ALU operand drive.
REQ-014 alu_op  output  5  ALU opcode drive.
REQ-015 alu_q  input  16  ALU result.
REQ-016 alu_ovf  input  1  ALU overflow/carry-out.

Function
REQ-017 States SHALL be IDLE, ITER and DONE, with a 4-bit iteration counter.
REQ-018 IDLE SHALL go to ITER on start=1; it SHALL clear the counter, P/R to 0, and load operand regs: mcand=a_in and M=b_in for multiply, or divisor=b_in and D=a_in for divide.
REQ-019 Divide with b_in=0 SHALL go from IDLE directly to DONE with res_lo=0xFFFF, res_hi=a_in, div_zero=1.
REQ-020 Multiply ITER SHALL drive alu_op=00001 (ADD), alu_a = M[0] ? mcand : 0, alu_b = P.
REQ-021 Each multiply ITER edge SHALL update P={alu_ovf, alu_q[15:1]} and M={alu_q[0], M[15:1]}.
REQ-022 Divide ITER SHALL form S={R[14:0], D[15]} and drive alu_op=00011 (SUB), alu_a=S, alu_b=divisor.
REQ-023 Each divide ITER edge SHALL compute qbit = R[15] | alu_ovf, then update R = qbit ? alu_q : S and D = {D[14:0], qbit}.
REQ-024 ITER SHALL run exactly 16 cycles; on the edge where the counter is 15 it SHALL go to DONE.
REQ-025 In IDLE and DONE the block SHALL drive alu_op=00000, alu_a=0, alu_b=0.
REQ-026 busy SHALL be 1 only in ITER; done SHALL be 1 only in DONE.
REQ-027 DONE SHALL go to IDLE unconditionally after one cycle.
REQ-028 Latency: with start sampled at edge N, busy SHALL be high from N+1 to N+16 and done high in the cycle after edge N+16 (divide-by-zero: done high in the cycle after edge N).
REQ-029 start in ITER or DONE SHALL be ignored and not queued.
REQ-030 res_hi/res_lo SHALL read P/M (multiply) or R/D (divide) registers, and SHALL hold from DONE until the next accepted start.
REQ-031 div_zero SHALL clear on the next accepted start.
REQ-032 Arithmetic SHALL be unsigned only; the 32-bit product cannot overflow and no overflow flag is produced.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, counter=0, busy=0, done=0, div_zero=0, res_lo=res_hi=0, and all internal operand regs to 0.
REQ-034 Reset asserted during ITER SHALL abort the operation with no done pulse; the first start after release SHALL be processed normally.

Verification (bench instantiates ALU wired to alu_* ports)
REQ-035 Multiply 0x1234 x 0x0010 -> done 17 cycles after start, res_hi=0x0001, res_lo=0x2340, div_zero=0.
REQ-036 Multiply 0xFFFF x 0xFFFF -> res_hi=0xFFFE, res_lo=0x0001; multiply 0x0000 x 0xABCD -> 0x0000/0x0000.
REQ-037 Divide 0x1234 / 0x0010 -> res_lo=0x0123, res_hi=0x0004; divide 0xFFFF / 0x0001 -> res_lo=0xFFFF, res_hi=0x0000; divide 0x0005 / 0xFFFF -> res_lo=0x0000, res_hi=0x0005.
REQ-038 Divide 0x8000 / 0x0000 -> done one cycle after start, res_lo=0xFFFF, res_hi=0x8000, div_zero=1; the next valid start clears div_zero.
REQ-039 start pulsed mid-ITER with different operands -> first result unaffected and exactly one done pulse; start held high continuously -> back-to-back operations spaced 18 cycles apart.
REQ-040 rst_n low at iteration 8 -> busy=0, res=0, no done; a following multiply 3 x 5 -> res_hi=0x0000, res_lo=0x000F.
